// File: rtl/adder_serial_ctrl.sv
// adder_serial_ctrl: WIDTH-bit add with carry-in, sequenced two bits per cycle through an external adder_2 slice.
module adder_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_c_in,
  input  logic [1:0]       slice_s,
  input  logic             slice_c_out
);
  localparam int NSLICE = WIDTH / 2;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run;
  assign run         = state_q == RUN;
  assign start_ready = state_q == IDLE;
  assign done_valid  = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign slice_a     = run ? a_q[{cnt_q, 1'b0} +: 2] : 2'b00;
  assign slice_b     = run ? b_q[{cnt_q, 1'b0} +: 2] : 2'b00;
  assign slice_c_in  = run & carry_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = c_in;
        cnt_d   = '0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[{cnt_q, 1'b0} +: 2] = slice_s;
        carry_d = slice_c_out;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSLICE - 1)) begin
          c_out_d = slice_c_out;
          state_d = DONE;
        end
      end
      DONE: state_d = done_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
